// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sharing controller.
// Operand/result widths match the shared multiply_n_divide_top instance.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DATA_W = 64;
    localparam int RES_W  = 129;

    // Quotient reported for a divide by zero; the remainder field carries A.
    localparam logic [DATA_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ. Returns a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    always_comb begin : pick
        logic [PTR_W:0]   pos;
        logic [PTR_W-1:0] sel;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NREQ)) begin
                pos = pos - (PTR_W+1)'(NREQ);
            end
            sel = pos[PTR_W-1:0];
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/muldiv_share_ctrl.sv
// Round-robin front end for one shared multiply/divide unit: one operation in
// flight, divide-by-zero and hung-unit cases answered with an error response.
//
// state | meaning
// IDLE  | arbitrate; accept winner, latch operands (div-by-0 skips to RESP)
// ISSUE | one-cycle start pulse to the unit, arm the timeout timer
// WAIT  | wait for unit ready (ignored in first cycle) or timer expiry
// RESP  | present response to owner until its rsp_ready
module muldiv_share_ctrl
    import muldiv_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024,
    parameter int PTR_W   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_m_d,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [RES_W-1:0]       rsp_result,
    output logic                   rsp_err,
    output logic                   mdu_start,
    output logic                   mdu_m_d,
    output logic [DATA_W-1:0]      mdu_a,
    output logic [DATA_W-1:0]      mdu_b,
    input  logic [RES_W-1:0]       mdu_result,
    input  logic                   mdu_ready,
    output logic                   busy
);

    localparam int               TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   idx;
    logic [NREQ-1:0]    grant;
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic [DATA_W-1:0]  win_a;
    logic [DATA_W-1:0]  win_b;
    logic               win_m_d;
    logic               win_div0;
    logic [TMR_W-1:0]   tmr;
    logic               grant_now;
    logic               wait_done;
    logic               wait_tout;
    logic               rsp_hs;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .found (win_found)
    );

    assign win_a    = req_a[int'(win_idx)*DATA_W +: DATA_W];
    assign win_b    = req_b[int'(win_idx)*DATA_W +: DATA_W];
    assign win_m_d  = req_m_d[win_idx];
    assign win_div0 = !win_m_d && (win_b == '0);

    assign grant_now = (state == ST_IDLE) && win_found;
    // The timer still holds its load value only in the first WAIT cycle, when
    // the unit's ready is stale from before the start pulse.
    assign wait_done = (state == ST_WAIT) && (tmr != TMR_LOAD) && mdu_ready;
    assign wait_tout = (state == ST_WAIT) && !wait_done && (tmr == '0);
    assign rsp_hs    = (state == ST_RESP) && rsp_ready[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    state_nxt = win_div0 ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wait_done || wait_tout) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Accept strobe is combinational from the arbiter, so hold it off while
    // reset is asserted to keep every output quiet during reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mdu_start = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (!reset) begin
                    req_ready = grant;
                end
            end
            ST_ISSUE: mdu_start = 1'b1;
            ST_RESP:  rsp_valid[idx] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            idx        <= '0;
            mdu_m_d    <= 1'b0;
            mdu_a      <= '0;
            mdu_b      <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            tmr        <= '0;
        end else begin
            if (grant_now) begin
                idx     <= win_idx;
                ptr     <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                mdu_m_d <= win_m_d;
                mdu_a   <= win_a;
                mdu_b   <= win_b;
                if (win_div0) begin
                    rsp_result <= {1'b0, win_a, DIV0_QUOT};
                    rsp_err    <= 1'b1;
                end
            end
            if (state == ST_ISSUE) begin
                tmr <= TMR_LOAD;
            end
            if (state == ST_WAIT) begin
                if (wait_done) begin
                    rsp_result <= mdu_result;
                    rsp_err    <= 1'b0;
                end else if (wait_tout) begin
                    rsp_result <= '0;
                    rsp_err    <= 1'b1;
                end else begin
                    tmr <= tmr - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/muldiv_share_ctrl.md
Name: muldiv_share_ctrl

Overview:
- Arbitrates NREQ requesters onto one shared multiply_n_divide_top instance (64-bit operands, 129-bit result, start/ready).
- Round-robin grant; one operation in flight at a time.
- Sequences the unit's start/ready, returns the result only to the granted requester, and short-circuits divide-by-zero and hung operations into error responses.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, max cycles in WAIT before an error response is forced.
- PTR_W, $clog2(NREQ), width of the round-robin pointer.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester operation request.
- req_ready  output  NREQ  one-hot accept; high only in the accept cycle.
- req_m_d  input  NREQ  per-requester op: 1 = multiply, 0 = divide.
- req_a  input  NREQ*64  packed operand A (dividend); requester i at [64i+63:64i].
- req_b  input  NREQ*64  packed operand B (divisor).
- rsp_valid  output  NREQ  one-hot response valid to the owning requester.
- rsp_ready  input  NREQ  per-requester response accept.
- rsp_result  output  129  response payload.
- rsp_err  output  1  response is an error (div-by-zero or timeout).
- mdu_start  output  1  start pulse to the shared unit.
- mdu_m_d  output  1  op to the unit.
- mdu_a  output  64  operand A to the unit.
- mdu_b  output  64  operand B to the unit.
- mdu_result  input  129  unit result.
- mdu_ready  input  1  unit done/idle.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, active-high) clears all outputs: req_ready, rsp_valid, rsp_result, rsp_err, mdu_start, mdu_m_d, mdu_a, mdu_b, busy. Pointer resets to 0; state resets to IDLE.
- Unit result format:
  - multiply: product in [127:0], bit 128 = 0.
  - divide: quotient in [63:0], remainder in [127:64], bit 128 = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pick the first valid requester at or after the pointer, wrapping modulo NREQ.
  - Pulse req_ready for the winner for one cycle. Latch its index, op and operands into mdu_* registers.
  - Pointer becomes winner+1 (mod NREQ).
  - If op = divide and B = 0: go to RESP with rsp_result = {1'b0, A, 64'hFFFF_FFFF_FFFF_FFFF} and rsp_err = 1. The unit is not started.
  - Otherwise go to ISSUE.
- ISSUE: mdu_start = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - mdu_ready is ignored in the first WAIT cycle (the unit drops ready the cycle after start).
  - From the second WAIT cycle, mdu_ready = 1 captures mdu_result into rsp_result with rsp_err = 0, then go to RESP.
  - If the counter reaches TIMEOUT-1 without ready: rsp_result = 0, rsp_err = 1, go to RESP.
- RESP:
  - rsp_valid[idx] = 1, with rsp_result and rsp_err held stable until rsp_ready[idx] = 1.
  - On that handshake cycle: drop rsp_valid and return to IDLE. A new grant can occur no earlier than the following cycle.
- Latency: accept at cycle T; mdu_start at T+1; rsp_valid at cycle R+1, where R is the cycle mdu_ready is sampled high. Div-by-zero response: rsp_valid at T+1.
- req_ready is never asserted outside IDLE. Requests held across busy periods remain pending and are not lost.
- rsp_ready on a non-owning requester is ignored.
- mdu_a, mdu_b and mdu_m_d hold stable from ISSUE until the next grant.
- Reset mid-operation returns to IDLE immediately. The shared unit shares the same reset; no response is emitted for the aborted operation.

Decomposition:
- Package muldiv_pkg: state encoding (IDLE/ISSUE/WAIT/RESP), DATA_W = 64, RES_W = 129, DIV0_QUOT all-ones constant.
- One sub-module, rr_arbiter: NREQ request vector plus pointer in, one-hot grant and encoded index out. Combinational, reused elsewhere.

Test Plan:
- Single multiply: requester 0, A = 3, B = 7, m_d = 1; unit stub with 5-cycle latency.
  -> rsp_valid[0], rsp_result = 21, rsp_err = 0; mdu_start high exactly 1 cycle.
- Single divide: requester 2, A = 100, B = 7.
  -> quotient field 14, remainder field 2, rsp_err = 0.
- Contention: all 4 requesters valid together, pointer 0.
  -> grant order 0, 1, 2, 3, 0; each response delivered only to its owner.
- Divide-by-zero: A = 55, B = 0.
  -> rsp_valid one cycle after accept; quotient field all-ones, remainder field 55, rsp_err = 1; mdu_start never asserted.
- Timeout: stub holds mdu_ready = 0, TIMEOUT = 16.
  -> rsp_err = 1, rsp_result = 0 after 16 WAIT cycles; next request still served.
- Reset asserted in WAIT with rsp_ready stalled.
  -> all outputs 0 asynchronously, busy = 0; after release, requester 1 multiply 6 × 9 returns 54.
